// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: one shared ALU and DMEM port sequenced by a six-state FSM.
// Build option: define FORWARD_BRANCH_EN to resolve beq/j in DECODE (2-cycle branches).
module multicycle_datapath #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 8,
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned DMEM_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_run,
  input  logic                          i_imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] i_imem_waddr,
  input  logic [31:0]                   i_imem_wdata,
  output logic [$clog2(IMEM_DEPTH)-1:0] o_pc,
  output logic [2:0]                    o_state,
  output logic                          o_halted,
  output logic                          o_error,
  output logic [15:0]                   o_retired
);

  localparam int unsigned PcW  = $clog2(IMEM_DEPTH);
  localparam int unsigned RegW = $clog2(NREGS);
  localparam int unsigned DaW  = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpHalt  = 6'h3F;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  state_e r_state, w_state_next;

  logic [PcW-1:0]  r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_a, r_b, r_imm, r_aluout, r_mdr;
  logic            r_halted, r_error;
  logic [15:0]     r_retired;
  logic [XLEN-1:0] r_rf   [NREGS];
  logic [XLEN-1:0] r_dmem [DMEM_DEPTH];
  logic [31:0]     r_imem [IMEM_DEPTH];

  logic [5:0]      w_op, w_funct;
  logic [4:0]      w_shamt;
  logic [RegW-1:0] w_rs, w_rt, w_rd, w_wb_idx;
  logic [DaW-1:0]  w_daddr;
  logic [XLEN-1:0] w_imm, w_alu, w_wb_data;
  logic [PcW-1:0]  w_pc_target;
  logic            w_op_legal, w_funct_legal, w_is_branch, w_beq_eq, w_take;
  logic            w_ir_we, w_dec_we, w_alu_we, w_pc_load, w_dm_we, w_mdr_we, w_rf_we;
  logic            w_retire, w_stop, w_set_err, w_start;
  logic            w_unused_ir;

  assign w_op        = r_ir[31:26];
  assign w_funct     = r_ir[5:0];
  assign w_shamt     = r_ir[10:6];
  assign w_rs        = r_ir[21 +: RegW];
  assign w_rt        = r_ir[16 +: RegW];
  assign w_rd        = r_ir[11 +: RegW];
  assign w_imm       = XLEN'($signed(r_ir[15:0]));
  assign w_daddr     = r_aluout[DaW-1:0];
  assign w_unused_ir = ^r_ir[25:16];

  assign w_op_legal  = (w_op == OpRtype) || (w_op == OpAddi) || (w_op == OpLw) ||
                       (w_op == OpSw) || (w_op == OpBeq) || (w_op == OpJ);
  assign w_is_branch = (w_op == OpBeq) || (w_op == OpJ);

  // Low PC bits of the immediate equal the low IR bits, so the branch target needs no sext.
  assign w_pc_target = (w_op == OpJ) ? r_ir[PcW-1:0] : r_pc + r_ir[PcW-1:0];
`ifdef FORWARD_BRANCH_EN
  assign w_beq_eq    = (r_rf[w_rs] == r_rf[w_rt]);
`else
  assign w_beq_eq    = (r_a == r_b);
`endif
  assign w_take      = (w_op == OpJ) || ((w_op == OpBeq) && w_beq_eq);

  assign w_wb_idx    = (w_op == OpRtype) ? w_rd : w_rt;
  assign w_wb_data   = (w_op == OpLw) ? r_mdr : r_aluout;

  always_comb begin
    w_alu         = r_a + r_imm;
    w_funct_legal = 1'b1;
    if (w_op == OpRtype) begin
      case (w_funct)
        6'h20:   w_alu = r_a + r_b;
        6'h22:   w_alu = r_a - r_b;
        6'h24:   w_alu = r_a & r_b;
        6'h25:   w_alu = r_a | r_b;
        6'h2A:   w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
        6'h00:   w_alu = r_b << w_shamt;
        default: w_funct_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (i_run && !r_error) w_state_next = StFetch;
      StFetch:  w_state_next = StDecode;
      StDecode: begin
        if ((w_op == OpHalt) || !w_op_legal) w_state_next = StIdle;
`ifdef FORWARD_BRANCH_EN
        else if (w_is_branch)                w_state_next = StFetch;
`endif
        else                                 w_state_next = StExec;
      end
      StExec: begin
        if ((w_op == OpRtype) && !w_funct_legal)    w_state_next = StIdle;
        else if (w_is_branch)                       w_state_next = StFetch;
        else if ((w_op == OpLw) || (w_op == OpSw))  w_state_next = StMem;
        else                                        w_state_next = StWb;
      end
      StMem:    w_state_next = (w_op == OpLw) ? StWb : StFetch;
      StWb:     w_state_next = StFetch;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_ir_we   = (r_state == StFetch);
    w_dec_we  = (r_state == StDecode);
    w_alu_we  = (r_state == StExec);
`ifdef FORWARD_BRANCH_EN
    w_pc_load = (r_state == StDecode) && w_is_branch && w_take;
`else
    w_pc_load = (r_state == StExec) && w_is_branch && w_take;
`endif
    w_dm_we   = (r_state == StMem) && (w_op == OpSw);
    w_mdr_we  = (r_state == StMem) && (w_op == OpLw);
    w_rf_we   = (r_state == StWb);
    // Only completed instructions re-enter FETCH from a non-IDLE state.
    w_retire  = (w_state_next == StFetch) && (r_state != StIdle);
    w_stop    = (w_state_next == StIdle) && (r_state != StIdle);
    w_set_err = w_stop && (w_op != OpHalt);
    w_start   = (r_state == StIdle) && (w_state_next == StFetch);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_aluout  <= '0;
      r_mdr     <= '0;
      r_halted  <= 1'b0;
      r_error   <= 1'b0;
      r_retired <= '0;
      for (int i = 0; i < NREGS; i++)      r_rf[i]   <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= '0;
    end else begin
      if (w_ir_we) begin
        r_ir <= r_imem[r_pc];
        r_pc <= r_pc + PcW'(1);
      end else if (w_pc_load) begin
        r_pc <= w_pc_target;
      end
      if (w_dec_we) begin
        r_a   <= r_rf[w_rs];
        r_b   <= r_rf[w_rt];
        r_imm <= w_imm;
      end
      if (w_alu_we) r_aluout <= w_alu;
      if (w_dm_we)  r_dmem[w_daddr] <= r_b;
      if (w_mdr_we) r_mdr <= r_dmem[w_daddr];
      if (w_rf_we && (w_wb_idx != '0)) r_rf[w_wb_idx] <= w_wb_data;
      if (w_start)     r_halted <= 1'b0;
      else if (w_stop) r_halted <= 1'b1;
      if (w_set_err) r_error <= 1'b1;
      if (w_retire && (r_retired != 16'hFFFF)) r_retired <= r_retired + 16'd1;
    end
  end

  // IMEM has no reset so a loaded program survives a core reset.
  always_ff @(posedge i_clk) begin
    if (i_imem_we && (r_state == StIdle)) r_imem[i_imem_waddr] <= i_imem_wdata;
  end

  assign o_pc      = r_pc;
  assign o_state   = r_state;
  assign o_halted  = r_halted;
  assign o_error   = r_error;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench: an ISA-level interpreter predicts final state and cycle count per program,
// a monitor compares when the core halts.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run, we, run2, we2;
  logic [3:0]  waddr, waddr2, pc, pc2;
  logic [31:0] wdata, wdata2;
  logic [2:0]  state, state2;
  logic        halted, error, halted2, error2;
  logic [15:0] retired, retired2;

  always #5 clk = ~clk;

  multicycle_datapath dut (
    .i_clk(clk), .i_reset(rst_n), .i_run(run), .i_imem_we(we), .i_imem_waddr(waddr),
    .i_imem_wdata(wdata), .o_pc(pc), .o_state(state), .o_halted(halted), .o_error(error),
    .o_retired(retired)
  );

  multicycle_datapath #(.XLEN(16), .NREGS(4), .IMEM_DEPTH(16), .DMEM_DEPTH(8)) dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_run(run2), .i_imem_we(we2), .i_imem_waddr(waddr2),
    .i_imem_wdata(wdata2), .o_pc(pc2), .o_state(state2), .o_halted(halted2), .o_error(error2),
    .o_retired(retired2)
  );

`ifdef FORWARD_BRANCH_EN
  localparam int BrCost = 2;
`else
  localparam int BrCost = 3;
`endif
  localparam logic [31:0] HALT = 32'hFC00_0000;

  typedef struct {
    logic [3:0]        pc;
    logic [15:0]       retired;
    logic              err;
    int                cycles;
    logic [7:0][31:0]  rf;
    logic [7:0][31:0]  dm;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] prog [16];
  int          n_tests = 0, n_fail = 0, n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Instruction-level interpreter starting from the post-reset machine state.
  task automatic model_run(output exp_t e);
    logic [31:0] rf [8];
    logic [31:0] dm [8];
    logic [31:0] ins, a, b, imm, res;
    logic [3:0]  mpc;
    int          cyc, ret;
    bit          done, err, bad;
    for (int i = 0; i < 8; i++) begin rf[i] = 0; dm[i] = 0; end
    mpc = 0; cyc = 0; ret = 0; done = 0; err = 0;
    for (int step = 0; step < 500 && !done; step++) begin
      ins = prog[mpc];
      mpc = mpc + 4'd1;
      a   = rf[ins[23:21]];
      b   = rf[ins[18:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      bad = 0;
      res = 0;
      case (ins[31:26])
        6'h3F: begin cyc += 2; done = 1; end
        6'h00: begin
          case (ins[5:0])
            6'h20:   res = a + b;
            6'h22:   res = a - b;
            6'h24:   res = a & b;
            6'h25:   res = a | b;
            6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00:   res = b * (32'd1 << ins[10:6]);
            default: bad = 1;
          endcase
          if (bad) begin cyc += 3; err = 1; done = 1; end
          else begin
            if (ins[13:11] != 0) rf[ins[13:11]] = res;
            cyc += 4; ret++;
          end
        end
        6'h08: begin
          if (ins[18:16] != 0) rf[ins[18:16]] = a + imm;
          cyc += 4; ret++;
        end
        6'h23: begin
          res = a + imm;
          if (ins[18:16] != 0) rf[ins[18:16]] = dm[res[2:0]];
          cyc += 5; ret++;
        end
        6'h2B: begin
          res = a + imm;
          dm[res[2:0]] = b;
          cyc += 4; ret++;
        end
        6'h04: begin
          if (a == b) mpc = mpc + imm[3:0];
          cyc += BrCost; ret++;
        end
        6'h02: begin mpc = ins[3:0]; cyc += BrCost; ret++; end
        default: begin cyc += 2; err = 1; done = 1; end
      endcase
    end
    e.pc = mpc; e.retired = 16'(ret); e.err = err; e.cycles = cyc;
    for (int i = 0; i < 8; i++) begin e.rf[i] = rf[i]; e.dm[i] = dm[i]; end
  endtask

  // Monitor: counts busy cycles and checks the scoreboard whenever the core halts.
  initial begin
    logic [2:0] prev;
    int         cnt;
    exp_t       e;
    prev = 0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (state != 3'd0) cnt++;
      else begin
        if (prev != 3'd0 && halted) begin
          chk("sb_entry", 64'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("pc", pc, e.pc);
            chk("retired", retired, e.retired);
            chk("error", error, e.err);
            chk("cycles", cnt, e.cycles);
            for (int i = 0; i < 8; i++) begin
              chk($sformatf("r%0d", i), dut.r_rf[i], e.rf[i]);
              chk($sformatf("dmem%0d", i), dut.r_dmem[i], e.dm[i]);
            end
          end
          n_done++;
        end
        cnt = 0;
      end
      prev = state;
    end
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 32'h0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); we = 1'b1; waddr = 4'(i); wdata = prog[i];
    end
    @(negedge clk); we = 1'b0;
  endtask

  task automatic run_prog();
    exp_t e;
    int   start;
    do_reset();
    load_prog();
    model_run(e);
    sb_q.push_back(e);
    start = n_done;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    for (int c = 0; c < 1000 && n_done == start; c++) @(negedge clk);
    chk("run_done", 64'(n_done != start), 1);
  endtask

  function automatic logic [31:0] rand_ins(int a);
    int          k, fsel;
    logic [25:0] t;
    logic [5:0]  fns [6];
    logic [5:0]  bad_ops [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    bad_ops = '{6'h11, 6'h01, 6'h3E, 6'h10, 6'h2C};
    k = $urandom_range(0, 9);
    case (k)
      0, 1: begin
        fsel = $urandom_range(0, 15);
        return enc_r($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), (fsel < 6) ? int'(fns[fsel]) :
                     (fsel == 15) ? 'h21 : int'(fns[fsel % 6]));
      end
      2, 3: return enc_i('h08, $urandom_range(0, 31), $urandom_range(0, 31), $urandom());
      4:    return enc_i('h23, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 15));
      5:    return enc_i('h2B, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 15));
      6:    return enc_i('h04, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 14 - a));
      7: begin
        t = 26'($urandom());
        t[3:0] = 4'($urandom_range(a + 1, 15));
        return enc_j(t);
      end
      8: begin
        if ($urandom_range(0, 3) == 0) return {bad_ops[$urandom_range(0, 4)], 26'($urandom())};
        return enc_i('h08, 0, $urandom_range(1, 7), $urandom_range(0, 100));
      end
      default: return enc_i('h08, 0, $urandom_range(0, 7), $urandom());
    endcase
  endfunction

  initial begin
    bit found;
    run = 0; we = 0; waddr = 0; wdata = 0;
    run2 = 0; we2 = 0; waddr2 = 0; wdata2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    chk("rst_retired", retired, 0);
    rst_n = 1'b1;

    // Add with preloaded operands.
    clear_prog();
    prog[0] = enc_i('h08, 0, 1, 5);
    prog[1] = enc_i('h08, 0, 2, 9);
    prog[2] = enc_r(1, 2, 3, 0, 'h20);
    prog[3] = HALT;
    run_prog();
    chk("t1_r3", dut.r_rf[3], 14);
    chk("t1_pc", pc, 4);
    chk("t1_retired", retired, 3);
    chk("t1_halted", halted, 1);

    // Arithmetic mix and r0 write discard.
    clear_prog();
    prog[0] = enc_i('h08, 0, 1, 7);
    prog[1] = enc_i('h08, 0, 2, -3);
    prog[2] = enc_r(1, 2, 3, 0, 'h22);
    prog[3] = enc_r(2, 1, 4, 0, 'h2A);
    prog[4] = enc_r(0, 1, 5, 2, 'h00);
    prog[5] = enc_i('h08, 0, 0, 5);
    prog[6] = HALT;
    run_prog();
    chk("t2_r3", dut.r_rf[3], 10);
    chk("t2_r4", dut.r_rf[4], 1);
    chk("t2_r5", dut.r_rf[5], 28);
    chk("t2_r0", dut.r_rf[0], 0);

    // Store then load through the same address.
    clear_prog();
    prog[0] = enc_i('h08, 0, 6, 2);
    prog[1] = enc_i('h08, 0, 4, 'h1C);
    prog[2] = enc_i('h2B, 6, 4, 1);
    prog[3] = enc_i('h23, 6, 5, 1);
    prog[4] = HALT;
    run_prog();
    chk("t3_dmem3", dut.r_dmem[3], 'h1C);
    chk("t3_r5", dut.r_rf[5], 'h1C);

    // Backward taken beq loop, then jump to a HALT in the last word.
    clear_prog();
    prog[0]  = enc_i('h08, 0, 1, 3);
    prog[1]  = enc_i('h08, 0, 4, 1);
    prog[2]  = enc_i('h08, 2, 2, 1);
    prog[3]  = enc_r(2, 1, 3, 0, 'h2A);
    prog[4]  = enc_i('h04, 3, 4, -3);
    prog[5]  = enc_j(26'd15);
    prog[15] = HALT;
    run_prog();
    chk("t4_counter", dut.r_rf[2], 3);
    chk("t4_pc", pc, 0);

    // Jump target wraps modulo the IMEM depth.
    clear_prog();
    prog[0] = enc_j(26'h13);
    prog[1] = enc_i('h08, 0, 1, 1);
    prog[2] = HALT;
    prog[3] = enc_i('h08, 0, 2, 2);
    prog[4] = HALT;
    run_prog();
    chk("t5_r1", dut.r_rf[1], 0);
    chk("t5_r2", dut.r_rf[2], 2);

    // Illegal opcode: sticky error, run ignored afterwards.
    clear_prog();
    prog[0] = enc_i('h08, 0, 1, 1);
    prog[1] = enc_i('h08, 0, 2, 2);
    prog[2] = 32'h4400_0000;
    run_prog();
    chk("t6_error", error, 1);
    chk("t6_pc", pc, 3);
    @(negedge clk); run = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_run_ignored", state, 0);
    run = 1'b0;
    chk("t6_still_halted", halted, 1);

    // Reset while lw sits in MEM.
    do_reset();
    clear_prog();
    prog[0] = enc_i('h08, 0, 6, 2);
    prog[1] = enc_i('h08, 0, 4, 'h1C);
    prog[2] = enc_i('h2B, 6, 4, 1);
    prog[3] = enc_i('h23, 6, 5, 1);
    prog[4] = HALT;
    load_prog();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (state == 3'd4 && retired == 16'd3) found = 1;
    end
    chk("t7_reached_mem", 64'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_r5", dut.r_rf[5], 0);
    chk("t7_pc", pc, 0);
    chk("t7_retired", retired, 0);
    chk("t7_state", state, 0);
    chk("t7_dmem3", dut.r_dmem[3], 0);
    @(negedge clk); rst_n = 1'b1;

    // Narrow build: 16-bit wrap into sign bit, rd field aliasing.
    clear_prog();
    prog[0] = enc_i('h08, 0, 1, 'h7FFF);
    prog[1] = enc_i('h08, 1, 1, 1);
    prog[2] = enc_r(1, 0, 6, 0, 'h20);
    prog[3] = HALT;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); we2 = 1'b1; waddr2 = 4'(i); wdata2 = prog[i];
    end
    @(negedge clk); we2 = 1'b0; run2 = 1'b1;
    @(negedge clk); run2 = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (halted2) found = 1;
    end
    chk("t8_halted", 64'(found), 1);
    chk("t8_r1", dut2.r_rf[1], 'h8000);
    chk("t8_r2_alias", dut2.r_rf[2], 'h8000);
    chk("t8_retired", retired2, 3);

    // Random forward-only programs ending in HALT.
    for (int n = 0; n < 30; n++) begin
      clear_prog();
      for (int a = 0; a < 15; a++) prog[a] = rand_ins(a);
      prog[15] = HALT;
      run_prog();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
